// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: widths, ALU opcodes, FSM state encoding, the EX/MEM slot
// record and the single-cycle ALU evaluation shared by the execute stage and
// the decode stage.
package ex_stage_pkg;

  localparam int REGADDR_WIDTH = 5;
  localparam int ALU_OPT_WIDTH = 4;

  typedef enum logic [ALU_OPT_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MUL  = 4'd12,
    ALU_DIVU = 4'd13,
    ALU_REMU = 4'd14,
    ALU_PASS = 4'd15
  } alu_opt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  // Contents of the EX/MEM pipeline register.
  typedef struct packed {
    logic                     valid;
    logic [31:0]              alu_result;
    logic [REGADDR_WIDTH-1:0] wb_reg_addr;
    logic                     wb_from_alu;
    logic                     mem_read;
    logic                     mem_write;
    logic [31:0]              mem_wdata;
  } ex2mem_slot_t;

  function automatic logic is_div_op(input logic [ALU_OPT_WIDTH-1:0] opt);
    return (opt == ALU_DIVU) || (opt == ALU_REMU);
  endfunction

  // Single-cycle operations; DIVU/REMU are produced by the iterative divider.
  function automatic logic [31:0] alu_eval(input logic [ALU_OPT_WIDTH-1:0] opt,
                                           input logic [31:0] o1,
                                           input logic [31:0] o2);
    logic [31:0] res;
    res = '0;
    case (alu_opt_e'(opt))
      ALU_ADD:  res = o1 + o2;
      ALU_SUB:  res = o1 - o2;
      ALU_AND:  res = o1 & o2;
      ALU_OR:   res = o1 | o2;
      ALU_XOR:  res = o1 ^ o2;
      ALU_NOR:  res = ~(o1 | o2);
      ALU_SLL:  res = o2 << o1[4:0];
      ALU_SRL:  res = o2 >> o1[4:0];
      ALU_SRA:  res = $unsigned($signed(o2) >>> o1[4:0]);
      ALU_SLT:  res = {31'd0, $signed(o1) < $signed(o2)};
      ALU_SLTU: res = {31'd0, o1 < o2};
      ALU_LUI:  res = {o2[15:0], 16'h0000};
      ALU_MUL:  res = o1 * o2;
      ALU_PASS: res = o2;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX -> EX -> MEM signal bundle of the execute stage.
//   id2ex_*   : forwarded operands and side-band fields from ID/EX
//   mem_stall : MEM cannot accept, EX/MEM must hold
//   ex_stall  : upstream must hold its id2ex_* fields (combinational)
//   ex2mem_*  : EX/MEM register contents, also fed back to forwarding
// master = pipeline around the stage, slave = ex_stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic                     id2ex_valid;
  logic [ALU_OPT_WIDTH-1:0] id2ex_alu_opt;
  logic [31:0]              id2ex_opr1;
  logic [31:0]              id2ex_opr2;
  logic [REGADDR_WIDTH-1:0] id2ex_wb_reg_addr;
  logic                     id2ex_wb_from_alu;
  logic                     id2ex_mem_read;
  logic                     id2ex_mem_write;
  logic [31:0]              id2ex_mem_wdata;
  logic                     mem_stall;
  logic                     ex_stall;
  logic                     ex2mem_valid;
  logic [31:0]              ex2mem_alu_result;
  logic [REGADDR_WIDTH-1:0] ex2mem_wb_reg_addr;
  logic                     ex2mem_wb_from_alu;
  logic                     ex2mem_mem_read;
  logic                     ex2mem_mem_write;
  logic [31:0]              ex2mem_mem_wdata;

  modport master (
    output id2ex_valid, id2ex_alu_opt, id2ex_opr1, id2ex_opr2,
           id2ex_wb_reg_addr, id2ex_wb_from_alu, id2ex_mem_read,
           id2ex_mem_write, id2ex_mem_wdata, mem_stall,
    input  ex_stall, ex2mem_valid, ex2mem_alu_result, ex2mem_wb_reg_addr,
           ex2mem_wb_from_alu, ex2mem_mem_read, ex2mem_mem_write,
           ex2mem_mem_wdata
  );

  modport slave (
    input  id2ex_valid, id2ex_alu_opt, id2ex_opr1, id2ex_opr2,
           id2ex_wb_reg_addr, id2ex_wb_from_alu, id2ex_mem_read,
           id2ex_mem_write, id2ex_mem_wdata, mem_stall,
    output ex_stall, ex2mem_valid, ex2mem_alu_result, ex2mem_wb_reg_addr,
           ex2mem_wb_from_alu, ex2mem_mem_read, ex2mem_mem_write,
           ex2mem_mem_wdata
  );
endinterface

// File: rtl/ex_stage_divu_iter.sv
// divu_iter: 32-step restoring unsigned divider.
//   start            : latch dividend/divisor, clear cnt, begin iterating
//   busy             : iterations in progress
//   last             : busy and cnt==31; the current edge performs step 32
//   cnt              : number of steps done
//   quo/rem          : registered quotient/remainder (final once !busy)
//   step_quo/step_rem: values the current step writes; at `last` they are
//                      the final result, available one edge early
module divu_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        last,
  output logic [4:0]  cnt,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic [31:0] step_quo,
  output logic [31:0] step_rem
);

  logic [31:0] divisor_q;
  logic [32:0] partial;

  // Shift {rem,quo} left by one; the partial remainder needs a 33rd bit
  // because rem < divisor can still exceed 2^31 before shifting.
  // A zero divisor always subtracts, giving quo=all ones and rem=dividend.
  always_comb begin
    // NOTE: assign defaults first so no path through the block leaves a
    // variable unassigned, which would infer a latch.
    partial  = {rem, quo[31]};
    step_quo = {quo[30:0], 1'b0};
    step_rem = partial[31:0];
    if (partial >= {1'b0, divisor_q}) begin
      step_rem = 32'(partial - {1'b0, divisor_q});
      step_quo = {quo[30:0], 1'b1};
    end
  end

  assign last = busy && (cnt == 5'd31);

  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset as well, so a reset mid-division
    // leaves no stale quotient/remainder behind; they are few flops.
    if (rst) begin
      busy      <= 1'b0;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      divisor_q <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= '0;
      quo       <= dividend;
      rem       <= '0;
      divisor_q <= divisor;
    end else if (busy) begin
      quo <= step_quo;
      rem <= step_rem;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage pipeline.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ex_stage_if.slave -- id2ex_* operands/side-band in,
//              mem_stall in, ex_stall out, ex2mem_* EX/MEM register out
// Single-cycle ALU ops land in EX/MEM one edge after acceptance. DIVU/REMU
// run on divu_iter for 32 edges while ex_stall holds upstream; the result
// is loaded on the 33rd edge, or later from DONE if MEM was stalling.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ex_stage_if.slave   bus
);

  ex_state_e    state;
  ex2mem_slot_t slot_q;
  ex2mem_slot_t slot_next;
  logic         load_slot;
  logic         div_start;
  logic         div_op;

  // Side-band fields of the divide in flight.
  logic                     div_is_rem;
  logic [REGADDR_WIDTH-1:0] div_wb_reg_addr;
  logic                     div_wb_from_alu;
  logic                     div_mem_read;
  logic                     div_mem_write;
  logic [31:0]              div_mem_wdata;

  logic        div_busy;
  logic        div_last;
  logic [4:0]  div_cnt;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [31:0] div_step_quo;
  logic [31:0] div_step_rem;
  logic [31:0] div_result;

  assign div_op = is_div_op(bus.id2ex_alu_opt);

  divu_iter u_divu_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (bus.id2ex_opr1),
    .divisor  (bus.id2ex_opr2),
    .busy     (div_busy),
    .last     (div_last),
    .cnt      (div_cnt),
    .quo      (div_quo),
    .rem      (div_rem),
    .step_quo (div_step_quo),
    .step_rem (div_step_rem)
  );

  // In RUN the final step is still being computed, so take the step output;
  // in DONE the divider registers already hold the result.
  always_comb begin
    if (state == ST_RUN) div_result = div_is_rem ? div_step_rem : div_quo_sel(div_step_quo);
    else                 div_result = div_is_rem ? div_rem : div_quo_sel(div_quo);
  end

  function automatic logic [31:0] div_quo_sel(input logic [31:0] q);
    return q;
  endfunction

  assign bus.ex_stall = bus.mem_stall
                      || (state == ST_IDLE && bus.id2ex_valid && div_op)
                      || (state == ST_RUN  && div_cnt != 5'd31)
                      || (state == ST_DONE && bus.mem_stall);

  // Next EX/MEM contents. The default is a bubble; result and store data
  // keep their old value since nothing downstream uses them when invalid.
  always_comb begin
    slot_next             = slot_q;
    slot_next.valid       = 1'b0;
    slot_next.wb_reg_addr = '0;
    slot_next.wb_from_alu = 1'b0;
    slot_next.mem_read    = 1'b0;
    slot_next.mem_write   = 1'b0;
    load_slot             = 1'b0;
    div_start             = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.mem_stall) begin
          load_slot = 1'b1;
          if (bus.id2ex_valid && div_op) begin
            div_start = 1'b1;
          end else if (bus.id2ex_valid) begin
            slot_next.valid       = 1'b1;
            slot_next.alu_result  = alu_eval(bus.id2ex_alu_opt, bus.id2ex_opr1,
                                             bus.id2ex_opr2);
            slot_next.wb_reg_addr = bus.id2ex_wb_reg_addr;
            slot_next.wb_from_alu = bus.id2ex_wb_from_alu;
            slot_next.mem_read    = bus.id2ex_mem_read;
            slot_next.mem_write   = bus.id2ex_mem_write;
            slot_next.mem_wdata   = bus.id2ex_mem_wdata;
          end
        end
      end
      ST_RUN, ST_DONE: begin
        if (!bus.mem_stall) begin
          load_slot = 1'b1;
          if (state == ST_DONE || div_last) begin
            slot_next.valid       = 1'b1;
            slot_next.alu_result  = div_result;
            slot_next.wb_reg_addr = div_wb_reg_addr;
            slot_next.wb_from_alu = div_wb_from_alu;
            slot_next.mem_read    = div_mem_read;
            slot_next.mem_write   = div_mem_write;
            slot_next.mem_wdata   = div_mem_wdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state           <= ST_IDLE;
      slot_q          <= '0;
      div_is_rem      <= 1'b0;
      div_wb_reg_addr <= '0;
      div_wb_from_alu <= 1'b0;
      div_mem_read    <= 1'b0;
      div_mem_write   <= 1'b0;
      div_mem_wdata   <= '0;
    end else begin
      if (load_slot) slot_q <= slot_next;
      case (state)
        ST_IDLE: begin
          if (div_start) begin
            state           <= ST_RUN;
            div_is_rem      <= (bus.id2ex_alu_opt == ALU_REMU);
            div_wb_reg_addr <= bus.id2ex_wb_reg_addr;
            div_wb_from_alu <= bus.id2ex_wb_from_alu;
            div_mem_read    <= bus.id2ex_mem_read;
            div_mem_write   <= bus.id2ex_mem_write;
            div_mem_wdata   <= bus.id2ex_mem_wdata;
          end
        end
        ST_RUN: begin
          if (div_last) state <= bus.mem_stall ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          if (!bus.mem_stall) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ex2mem_valid       = slot_q.valid;
  assign bus.ex2mem_alu_result  = slot_q.alu_result;
  assign bus.ex2mem_wb_reg_addr = slot_q.wb_reg_addr;
  assign bus.ex2mem_wb_from_alu = slot_q.wb_from_alu;
  assign bus.ex2mem_mem_read    = slot_q.mem_read;
  assign bus.ex2mem_mem_write   = slot_q.mem_write;
  assign bus.ex2mem_mem_wdata   = slot_q.mem_wdata;

  logic unused_div_busy;
  assign unused_div_busy = div_busy;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12] = '{
    '{4'd0,  32'd5,        32'd7,        32'd12},
    '{4'd1,  32'd0,        32'd1,        32'hFFFF_FFFF},
    '{4'd8,  32'd4,        32'h8000_0000, 32'hF800_0000},
    '{4'd7,  32'd4,        32'h8000_0000, 32'h0800_0000},
    '{4'd9,  32'hFFFF_FFFF, 32'd1,        32'd1},
    '{4'd10, 32'hFFFF_FFFF, 32'd1,        32'd0},
    '{4'd11, 32'h0,        32'h1234_ABCD, 32'hABCD_0000},
    '{4'd5,  32'h0F0F_0000, 32'h00FF_00FF, 32'hF000_FF00},
    '{4'd12, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000},
    '{4'd6,  32'd31,       32'd1,        32'h8000_0000},
    '{4'd4,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0},
    '{4'd15, 32'd0,        32'hDEAD_BEEF, 32'hDEAD_BEEF}
  };

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.id2ex_valid       = 1'b0;
    bus.id2ex_alu_opt     = '0;
    bus.id2ex_opr1        = '0;
    bus.id2ex_opr2        = '0;
    bus.id2ex_wb_reg_addr = '0;
    bus.id2ex_wb_from_alu = 1'b0;
    bus.id2ex_mem_read    = 1'b0;
    bus.id2ex_mem_write   = 1'b0;
    bus.id2ex_mem_wdata   = '0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] o1, input logic [31:0] o2,
                          input logic [4:0] wb, input logic mw, input logic [31:0] wd);
    bus.id2ex_valid       = 1'b1;
    bus.id2ex_alu_opt     = op;
    bus.id2ex_opr1        = o1;
    bus.id2ex_opr2        = o2;
    bus.id2ex_wb_reg_addr = wb;
    bus.id2ex_wb_from_alu = 1'b1;
    bus.id2ex_mem_read    = 1'b0;
    bus.id2ex_mem_write   = mw;
    bus.id2ex_mem_wdata   = wd;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " valid"},  {31'd0, bus.ex2mem_valid}, 32'd0);
    check({tag, " result"}, bus.ex2mem_alu_result, 32'd0);
    check({tag, " wb"},     {27'd0, bus.ex2mem_wb_reg_addr}, 32'd0);
    check({tag, " wbalu"},  {31'd0, bus.ex2mem_wb_from_alu}, 32'd0);
    check({tag, " mrd"},    {31'd0, bus.ex2mem_mem_read}, 32'd0);
    check({tag, " mwr"},    {31'd0, bus.ex2mem_mem_write}, 32'd0);
    check({tag, " wdata"},  bus.ex2mem_mem_wdata, 32'd0);
    check({tag, " stall"},  {31'd0, bus.ex_stall}, 32'd0);
  endtask

  // Full divide with MEM free: 32 stall cycles, 32 bubbles, result after E32.
  task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] o1,
                         input logic [31:0] o2, input logic [4:0] wb, input logic [31:0] exp);
    int stall_cycles;
    drive_op(op, o1, o2, wb, 1'b0, 32'd0);
    #1;
    stall_cycles = int'(bus.ex_stall);
    for (int i = 0; i < 32; i++) begin
      tick();
      check({tag, " bubble valid"}, {31'd0, bus.ex2mem_valid}, 32'd0);
      check({tag, " bubble wb"}, {27'd0, bus.ex2mem_wb_reg_addr}, 32'd0);
      stall_cycles += int'(bus.ex_stall);
    end
    check({tag, " stall cycles"}, 32'(stall_cycles), 32'd32);
    tick();
    check({tag, " valid"},  {31'd0, bus.ex2mem_valid}, 32'd1);
    check({tag, " result"}, bus.ex2mem_alu_result, exp);
    check({tag, " wb"},     {27'd0, bus.ex2mem_wb_reg_addr}, {27'd0, wb});
    drive_idle();
    tick();
    check({tag, " no reaccept"}, {31'd0, bus.ex2mem_valid}, 32'd0);
    check({tag, " idle stall"},  {31'd0, bus.ex_stall}, 32'd0);
  endtask

  initial begin
    drive_idle();
    bus.mem_stall = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b0;

    // Single-cycle operations, latency 1.
    for (int i = 0; i < 12; i++) begin
      drive_op(vecs[i].op, vecs[i].o1, vecs[i].o2, 5'(i + 1), i[0], 32'(i * 32'h11));
      #1;
      check($sformatf("op%0d stall", vecs[i].op), {31'd0, bus.ex_stall}, 32'd0);
      tick();
      check($sformatf("op%0d result", vecs[i].op), bus.ex2mem_alu_result, vecs[i].exp);
      check($sformatf("op%0d valid", vecs[i].op), {31'd0, bus.ex2mem_valid}, 32'd1);
      check($sformatf("op%0d wb", vecs[i].op), {27'd0, bus.ex2mem_wb_reg_addr}, 32'(i + 1));
      check($sformatf("op%0d mwr", vecs[i].op), {31'd0, bus.ex2mem_mem_write}, {31'd0, i[0]});
      check($sformatf("op%0d wdata", vecs[i].op), bus.ex2mem_mem_wdata, 32'(i * 32'h11));
    end

    // MEM stall holds the slot even with a new instruction offered.
    drive_op(4'd0, 32'd1, 32'd1, 5'd9, 1'b0, 32'd0);
    bus.mem_stall = 1'b1;
    #1;
    check("memstall ex_stall", {31'd0, bus.ex_stall}, 32'd1);
    tick();
    tick();
    check("memstall hold result", bus.ex2mem_alu_result, 32'hDEAD_BEEF);
    check("memstall hold wb", {27'd0, bus.ex2mem_wb_reg_addr}, 32'd12);
    bus.mem_stall = 1'b0;
    tick();
    check("post stall add", bus.ex2mem_alu_result, 32'd2);
    drive_idle();
    tick();
    check("bubble valid", {31'd0, bus.ex2mem_valid}, 32'd0);
    check("bubble wb", {27'd0, bus.ex2mem_wb_reg_addr}, 32'd0);
    check("bubble wbalu", {31'd0, bus.ex2mem_wb_from_alu}, 32'd0);

    run_div("divu 100/7", 4'd13, 32'd100, 32'd7, 5'd4, 32'd14);
    run_div("remu 100/7", 4'd14, 32'd100, 32'd7, 5'd5, 32'd2);
    run_div("divu 9/0",   4'd13, 32'd9,   32'd0, 5'd6, 32'hFFFF_FFFF);
    run_div("remu 9/0",   4'd14, 32'd9,   32'd0, 5'd7, 32'd9);

    // mem_stall raised at cnt=30 for 5 edges: FSM parks in DONE.
    drive_op(4'd13, 32'd100, 32'd7, 5'd8, 1'b0, 32'd0);
    for (int i = 0; i < 31; i++) tick();
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("done hold valid",  {31'd0, bus.ex2mem_valid}, 32'd0);
      check("done hold wb",     {27'd0, bus.ex2mem_wb_reg_addr}, 32'd0);
      check("done hold result", bus.ex2mem_alu_result, 32'd9);
      check("done hold stall",  {31'd0, bus.ex_stall}, 32'd1);
    end
    bus.mem_stall = 1'b0;
    #1;
    check("done release stall", {31'd0, bus.ex_stall}, 32'd0);
    tick();
    check("done result valid", {31'd0, bus.ex2mem_valid}, 32'd1);
    check("done result", bus.ex2mem_alu_result, 32'd14);
    check("done result wb", {27'd0, bus.ex2mem_wb_reg_addr}, 32'd8);
    drive_idle();
    tick();
    check("done no reaccept", {31'd0, bus.ex2mem_valid}, 32'd0);
    check("done idle stall", {31'd0, bus.ex_stall}, 32'd0);

    // Reset in the middle of a division.
    drive_op(4'd14, 32'd1000, 32'd3, 5'd10, 1'b1, 32'h5555_AAAA);
    for (int i = 0; i < 11; i++) tick();
    check("pre-reset stall", {31'd0, bus.ex_stall}, 32'd1);
    rst = 1'b1;
    drive_idle();
    tick();
    check_zero_outputs("mid-div reset");
    rst = 1'b0;
    tick();
    check("post-reset idle valid", {31'd0, bus.ex2mem_valid}, 32'd0);
    check("post-reset idle stall", {31'd0, bus.ex_stall}, 32'd0);
    drive_op(4'd0, 32'd2, 32'd3, 5'd7, 1'b0, 32'd0);
    tick();
    check("post-reset add result", bus.ex2mem_alu_result, 32'd5);
    check("post-reset add valid", {31'd0, bus.ex2mem_valid}, 32'd1);
    check("post-reset add wb", {27'd0, bus.ex2mem_wb_reg_addr}, 32'd7);
    drive_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
